// File: rtl/reg_rename_pkg.sv
// Shared types and widths for the register rename / architectural register file block.
package reg_rename_pkg;

    localparam int ROB_WIDTH     = 4;
    localparam int REG_IDX_WIDTH = 5;

    typedef struct packed {
        logic                 busy;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } src_t;

endpackage

// File: rtl/reg_rename_status_table.sv
// Per-register busy bit and owner tag: set on issue, tag-matched clear on commit,
// global clear on flush, two combinational read ports.
module reg_status_table #(
    parameter int NREG = 32,
    parameter int TW   = 4,
    parameter int IW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic [TW-1:0] set_tag,
    input  logic          clr_en,
    input  logic [IW-1:0] clr_idx,
    input  logic [TW-1:0] clr_tag,
    input  logic [IW-1:0] rd_idx  [2],
    output logic          rd_busy [2],
    output logic [TW-1:0] rd_tag  [2]
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [TW-1:0]   owner_q [NREG];
    logic [TW-1:0]   owner_d [NREG];

    // Next-state: flush beats set, and set beats a tag-matched clear to the same register.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        for (int r = 0; r < NREG; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (set_en && (set_idx == IW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (clr_en && (clr_idx == IW'(r)) && (owner_q[r] == clr_tag)) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
            if (set_en && !flush && (set_idx == IW'(r))) begin
                owner_d[r] = set_tag;
            end else begin
                owner_d[r] = owner_q[r];
            end
        end
    end

    // Busy/owner state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                owner_q[r] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    // Combinational read ports.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rd_busy[i] = busy_q[rd_idx[i]];
            rd_tag[i]  = owner_q[rd_idx[i]];
        end
    end

endmodule

// File: rtl/reg_rename.sv
// Architectural register file with rename status and ROB-tag destination table.
// Optional feature: define COMMIT_BYPASS_EN to forward a same-cycle commit onto src reads.
module reg_rename
    import reg_rename_pkg::*;
#(
    parameter int ROB_WIDTH = reg_rename_pkg::ROB_WIDTH,
    parameter int NREG      = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     issue,
    input  logic [ROB_WIDTH-1:0]     issue_tag,
    input  logic                     issue_dst_valid,
    input  logic [$clog2(NREG)-1:0]  issue_dst,
    input  logic [$clog2(NREG)-1:0]  src_idx [2],
    output src_t                     src     [2],
    input  logic                     commit,
    input  logic [ROB_WIDTH-1:0]     commit_tag,
    input  logic [31:0]              commit_data
);

    localparam int IW   = $clog2(NREG);
    localparam int NTAG = 1 << ROB_WIDTH;

    logic [31:0]          rf_q        [NREG];
    logic [31:0]          rf_d        [NREG];
    logic [NTAG-1:0]      dst_valid_q, dst_valid_d;
    logic [IW-1:0]        dst_idx_q   [NTAG];
    logic [IW-1:0]        dst_idx_d   [NTAG];

    logic                 cm_valid_s;
    logic [IW-1:0]        cm_idx_s;
    logic                 cm_wr_s;
    logic                 iss_set_s;
    logic                 rd_busy_s [2];
    logic [ROB_WIDTH-1:0] rd_tag_s  [2];

    // Decode the committing destination (from pre-edge dst table) and the issuing write.
    always_comb begin
        cm_valid_s = commit && dst_valid_q[commit_tag];
        cm_idx_s   = dst_idx_q[commit_tag];
        cm_wr_s    = cm_valid_s && (cm_idx_s != {IW{1'b0}});
        iss_set_s  = issue && issue_dst_valid && (issue_dst != {IW{1'b0}});
    end

    // Next-state for the data file and the destination table; dst is written even under flush.
    always_comb begin
        rf_d        = rf_q;
        dst_valid_d = dst_valid_q;
        dst_idx_d   = dst_idx_q;
        for (int r = 0; r < NREG; r++) begin
            if (cm_wr_s && (cm_idx_s == IW'(r))) begin
                rf_d[r] = commit_data;
            end else begin
                rf_d[r] = rf_q[r];
            end
        end
        for (int t = 0; t < NTAG; t++) begin
            if (issue && (issue_tag == ROB_WIDTH'(t))) begin
                dst_valid_d[t] = issue_dst_valid;
                dst_idx_d[t]   = issue_dst;
            end else begin
                dst_valid_d[t] = dst_valid_q[t];
                dst_idx_d[t]   = dst_idx_q[t];
            end
        end
    end

    // Data file and destination table registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dst_valid_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= 32'h0;
            end
            for (int t = 0; t < NTAG; t++) begin
                dst_idx_q[t] <= '0;
            end
        end else begin
            rf_q        <= rf_d;
            dst_valid_q <= dst_valid_d;
            dst_idx_q   <= dst_idx_d;
        end
    end

    reg_status_table #(
        .NREG (NREG),
        .TW   (ROB_WIDTH),
        .IW   (IW)
    ) u_status (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .set_en  (iss_set_s),
        .set_idx (issue_dst),
        .set_tag (issue_tag),
        .clr_en  (cm_valid_s),
        .clr_idx (cm_idx_s),
        .clr_tag (commit_tag),
        .rd_idx  (src_idx),
        .rd_busy (rd_busy_s),
        .rd_tag  (rd_tag_s)
    );

    // Operand read; register 0 is hardwired to zero.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            src[i] = '0;
            if (src_idx[i] == {IW{1'b0}}) begin
                src[i] = '0;
            end else begin
                src[i].busy = rd_busy_s[i];
                src[i].tag  = rd_tag_s[i];
                src[i].data = rf_q[src_idx[i]];
`ifdef COMMIT_BYPASS_EN
                if (cm_wr_s && (cm_idx_s == src_idx[i]) && (rd_tag_s[i] == commit_tag)) begin
                    src[i].busy = 1'b0;
                    src[i].data = commit_data;
                end else begin
                    src[i].busy = rd_busy_s[i];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_rename.sv
// Directed table-driven bench for reg_rename plus hand-written bypass and reset sequences.
module tb_reg_rename;
    import reg_rename_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        issue;
    logic [3:0]  issue_tag;
    logic        issue_dst_valid;
    logic [4:0]  issue_dst;
    logic [4:0]  src_idx [2];
    src_t        src     [2];
    logic        commit;
    logic [3:0]  commit_tag;
    logic [31:0] commit_data;

    int n_checks = 0;
    int n_err    = 0;

    reg_rename dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush           (flush),
        .issue           (issue),
        .issue_tag       (issue_tag),
        .issue_dst_valid (issue_dst_valid),
        .issue_dst       (issue_dst),
        .src_idx         (src_idx),
        .src             (src),
        .commit          (commit),
        .commit_tag      (commit_tag),
        .commit_data     (commit_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic [3:0]  itag;
        logic        idv;
        logic [4:0]  idst;
        logic        cm;
        logic [3:0]  ctag;
        logic [31:0] cdata;
        logic        fl;
        logic [4:0]  s0;
        logic [4:0]  s1;
        src_t        e0;
        src_t        e1;
    } vec_t;

    vec_t vq[$];

    function automatic src_t mk(input logic b, input logic [3:0] t, input logic [31:0] d);
        src_t s;
        s.busy = b;
        s.tag  = t;
        s.data = d;
        return s;
    endfunction

    task automatic add(input logic iss, input logic [3:0] itag, input logic idv, input logic [4:0] idst,
                       input logic cm, input logic [3:0] ctag, input logic [31:0] cdata, input logic fl,
                       input logic [4:0] s0, input logic [4:0] s1, input src_t e0, input src_t e1);
        vec_t v;
        v.iss = iss; v.itag = itag; v.idv = idv; v.idst = idst;
        v.cm = cm; v.ctag = ctag; v.cdata = cdata; v.fl = fl;
        v.s0 = s0; v.s1 = s1; v.e0 = e0; v.e1 = e1;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input src_t act, input src_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got busy=%0d tag=%0d data=%h, want busy=%0d tag=%0d data=%h",
                     name, act.busy, act.tag, act.data, exp.busy, exp.tag, exp.data);
        end
    endtask

    task automatic idle();
        flush = 1'b0; issue = 1'b0; issue_tag = 4'd0; issue_dst_valid = 1'b0; issue_dst = 5'd0;
        commit = 1'b0; commit_tag = 4'd0; commit_data = 32'h0;
    endtask

    src_t z;

    initial begin
        z = mk(1'b0, 4'd0, 32'h0);
        reset_n = 1'b0;
        idle();
        src_idx[0] = 5'd0;
        src_idx[1] = 5'd0;

        //   iss itag idv idst  cm ctag cdata          fl  s0     s1     e0                              e1
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd0,  z,                              z);
        add(1, 3,  1, 5,     0, 0,  32'h0,         0,  5'd5,  5'd0,  z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd0,  mk(1, 3, 32'h0),                z);
        add(0, 0,  0, 0,     1, 3,  32'hDEADBEEF,  0,  5'd1,  5'd0,  z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd1,  mk(0, 3, 32'hDEADBEEF),         z);
        add(1, 3,  1, 5,     0, 0,  32'h0,         0,  5'd5,  5'd6,  mk(0, 3, 32'hDEADBEEF),         z);
        add(1, 4,  1, 5,     0, 0,  32'h0,         0,  5'd5,  5'd6,  mk(1, 3, 32'hDEADBEEF),         z);
        add(0, 0,  0, 0,     1, 3,  32'd7,         0,  5'd5,  5'd6,  mk(1, 4, 32'hDEADBEEF),         z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd6,  mk(1, 4, 32'd7),                z);
        add(1, 2,  1, 5,     0, 0,  32'h0,         0,  5'd5,  5'd0,  mk(1, 4, 32'd7),                z);
        add(1, 6,  1, 5,     1, 2,  32'h55,        0,  5'd9,  5'd10, z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd0,  mk(1, 6, 32'h55),               z);
        add(0, 0,  0, 0,     1, 4,  32'h44,        0,  5'd5,  5'd0,  mk(1, 6, 32'h55),               z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd0,  mk(1, 6, 32'h44),               z);
        add(1, 1,  1, 0,     0, 0,  32'h0,         0,  5'd0,  5'd5,  z,                              mk(1, 6, 32'h44));
        add(0, 0,  0, 0,     1, 1,  32'd9,         0,  5'd0,  5'd1,  z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd0,  5'd1,  z,                              z);
        add(1, 7,  1, 1,     0, 0,  32'h0,         0,  5'd1,  5'd2,  z,                              z);
        add(1, 8,  1, 2,     0, 0,  32'h0,         0,  5'd1,  5'd2,  mk(1, 7, 32'h0),                z);
        add(1, 9,  1, 3,     0, 0,  32'h0,         0,  5'd1,  5'd3,  mk(1, 7, 32'h0),                z);
        add(1, 10, 1, 7,     1, 6,  32'h66,        1,  5'd1,  5'd2,  mk(1, 7, 32'h0),                mk(1, 8, 32'h0));
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd1,  5'd2,  mk(0, 7, 32'h0),                mk(0, 8, 32'h0));
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd3,  5'd7,  mk(0, 9, 32'h0),                z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd5,  5'd7,  mk(0, 6, 32'h66),               z);
        add(0, 0,  0, 0,     1, 10, 32'h77,        0,  5'd4,  5'd0,  z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd7,  5'd0,  mk(0, 0, 32'h77),               z);
        add(1, 15, 1, 9,     0, 0,  32'h0,         0,  5'd9,  5'd0,  z,                              z);
        add(1, 0,  1, 9,     0, 0,  32'h0,         0,  5'd9,  5'd0,  mk(1, 15, 32'h0),               z);
        add(0, 0,  0, 0,     1, 15, 32'hA,         0,  5'd9,  5'd0,  mk(1, 0, 32'h0),                z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd9,  5'd0,  mk(1, 0, 32'hA),                z);
        add(0, 0,  0, 0,     1, 0,  32'hB,         0,  5'd8,  5'd0,  z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd9,  5'd0,  mk(0, 0, 32'hB),                z);
        add(1, 12, 0, 11,    0, 0,  32'h0,         0,  5'd11, 5'd0,  z,                              z);
        add(0, 0,  0, 0,     1, 12, 32'hCC,        0,  5'd11, 5'd0,  z,                              z);
        add(0, 0,  0, 0,     0, 0,  32'h0,         0,  5'd11, 5'd0,  z,                              z);

        // Reset state before release.
        #2;
        chk("reset_src0", src[0], z);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            issue = vq[i].iss; issue_tag = vq[i].itag; issue_dst_valid = vq[i].idv; issue_dst = vq[i].idst;
            commit = vq[i].cm; commit_tag = vq[i].ctag; commit_data = vq[i].cdata; flush = vq[i].fl;
            src_idx[0] = vq[i].s0;
            src_idx[1] = vq[i].s1;
            #1;
            chk($sformatf("vec%0d.src0", i), src[0], vq[i].e0);
            chk($sformatf("vec%0d.src1", i), src[1], vq[i].e1);
        end

        // Same-cycle read of a committing register: pre-edge state, or forwarded with bypass.
        @(negedge clk);
        idle();
        issue = 1'b1; issue_tag = 4'd13; issue_dst_valid = 1'b1; issue_dst = 5'd12;
        @(negedge clk);
        idle();
        commit = 1'b1; commit_tag = 4'd13; commit_data = 32'h1234;
        src_idx[0] = 5'd12;
        src_idx[1] = 5'd0;
        #1;
`ifdef COMMIT_BYPASS_EN
        chk("same_cycle_commit_read", src[0], mk(1'b0, 4'd13, 32'h1234));
`else
        chk("same_cycle_commit_read", src[0], mk(1'b1, 4'd13, 32'h0));
`endif
        @(negedge clk);
        idle();
        #1;
        chk("after_commit_r12", src[0], mk(1'b0, 4'd13, 32'h1234));

        // Reset mid-stream with an issue and commit in flight.
        idle();
        issue = 1'b1; issue_tag = 4'd14; issue_dst_valid = 1'b1; issue_dst = 5'd13;
        @(negedge clk);
        issue = 1'b1; issue_tag = 4'd1; issue_dst_valid = 1'b1; issue_dst = 5'd14;
        commit = 1'b1; commit_tag = 4'd14; commit_data = 32'h999;
        src_idx[0] = 5'd12;
        src_idx[1] = 5'd13;
        #1;
        chk("pre_reset_r13_busy", src[1], mk(1'b1, 4'd14, 32'h0));
        #1;
        reset_n = 1'b0;
        #1;
        chk("reset_async_r12", src[0], z);
        chk("reset_async_r13", src[1], z);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        src_idx[0] = 5'd14;
        src_idx[1] = 5'd13;
        #1;
        chk("reset_dropped_issue_r14", src[0], z);
        chk("reset_dropped_commit_r13", src[1], z);
        @(negedge clk);
        commit = 1'b1; commit_tag = 4'd1; commit_data = 32'h31;
        @(negedge clk);
        idle();
        #1;
        chk("reset_cleared_dst_r14", src[0], z);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
